// File: rtl/button_event_if.sv
// Button event bus: debounced level in, registered event pulses out.
interface button_event_if;
    logic level_i;
    logic press_o;
    logic release_o;
    logic long_press_o;
    logic held_o;
    logic repeat_o;

    modport master (
        output level_i,
        input  press_o, release_o, long_press_o, held_o, repeat_o
    );

    modport slave (
        input  level_i,
        output press_o, release_o, long_press_o, held_o, repeat_o
    );
endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long-press/held events.
// Define BUTTON_EVENT_AUTO_REPEAT_EN to enable auto-repeat pulses while held.
module button_event #(
    parameter int unsigned COUNTER_BITS  = 6,
    parameter int unsigned HOLD_CYCLES   = 50,
    parameter int unsigned REPEAT_CYCLES = 10
) (
    input  logic          clock_i,
    input  logic          reset_i,
    button_event_if.slave bus
);

    if ((HOLD_CYCLES < 2) || (REPEAT_CYCLES < 1) ||
        (HOLD_CYCLES >= 2 ** COUNTER_BITS) || (REPEAT_CYCLES >= 2 ** COUNTER_BITS))
    begin : gen_bad_params
        $error("button_event: invalid HOLD_CYCLES/REPEAT_CYCLES/COUNTER_BITS");
    end

    typedef enum logic [1:0] {StLockout, StIdle, StPressed, StHeld} state_e;

    // Counter holds edges-since-entry minus one, so reaching N-1 marks the Nth edge.
    localparam logic [COUNTER_BITS-1:0] HoldLast = COUNTER_BITS'(HOLD_CYCLES - 1);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    localparam logic [COUNTER_BITS-1:0] RepLast = COUNTER_BITS'(REPEAT_CYCLES - 1);
    logic repeat_q;
`endif

    state_e                  state_q;
    logic [COUNTER_BITS-1:0] cnt_q;
    logic                    press_q;
    logic                    release_q;
    logic                    long_q;
    logic                    held_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StLockout;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
            case (state_q)
                StLockout: begin
                    if (!bus.level_i) state_q <= StIdle;
                end
                StIdle: begin
                    if (bus.level_i) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                    end
                end
                StPressed: begin
                    if (!bus.level_i) begin
                        state_q   <= StIdle;
                        release_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (cnt_q == HoldLast) begin
                        state_q <= StHeld;
                        long_q  <= 1'b1;
                        held_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHeld: begin
                    if (!bus.level_i) begin
                        state_q   <= StIdle;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                        cnt_q     <= '0;
                    end
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
                    else if (cnt_q == RepLast) begin
                        repeat_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= StLockout;
            endcase
        end
    end

    assign bus.press_o      = press_q;
    assign bus.release_o    = release_q;
    assign bus.long_press_o = long_q;
    assign bus.held_o       = held_q;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    assign bus.repeat_o     = repeat_q;
`else
    assign bus.repeat_o     = 1'b0;
`endif

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Consumes the debounced level from the debouncer and turns it into discrete, single-cycle user-input events: press, release, long-press and, optionally, auto-repeat.
- Sits between the debouncer and the operand-entry/control logic of the multiplier front panel.
- Runs on the 50 Hz system clock (20 ms period).
- All outputs are registered.

Parameters:
- COUNTER_BITS, 6, width of the internal cycle counter. Must satisfy 2^COUNTER_BITS > max(HOLD_CYCLES, REPEAT_CYCLES).
- HOLD_CYCLES, 50, clock cycles the level must stay high after a press before long_press fires (50 = 1 s). Must be ≥ 2.
- REPEAT_CYCLES, 10, clock cycles between repeat pulses once held (10 = 200 ms). Must be ≥ 1.

Ports:
- clock  input  1  system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-high reset
- level  input  1  debounced button level, synchronous to clock (1 = pressed)
- press  output  1  one-cycle pulse on accepted press
- release  output  1  one-cycle pulse on release of an accepted press
- long_press  output  1  one-cycle pulse when the hold threshold is reached
- held  output  1  high while in HELD state
- repeat  output  1  one-cycle auto-repeat pulse (optional feature)

Behaviour:
- reset asserted: state = LOCKOUT, counter = 0, all outputs 0, taking effect immediately (asynchronous).
  - Reset deassertion is synchronised by the integrating top level.
- States: LOCKOUT, IDLE, PRESSED, HELD.
- LOCKOUT:
  - level=1: stay.
  - level=0: go to IDLE.
  - Emits no events, so a button held through reset never produces press or release.
- IDLE, level=1 at edge N:
  - Go to PRESSED, counter := 0.
  - press=1 for the cycle following edge N only.
- PRESSED:
  - Each edge with level=1: counter += 1.
  - When counter+1 == HOLD_CYCLES (i.e. edge N+HOLD_CYCLES): go to HELD, long_press=1 for one cycle, held=1, counter := 0.
  - level=0 at any edge: go to IDLE, release=1 for one cycle, counter := 0.
  - No long_press is generated on release.
- HELD:
  - level=1: held stays 1; counter behaviour per the optional feature.
  - level=0: go to IDLE, release=1 one cycle, held := 0 registered on the same edge, repeat is not emitted that cycle.
- At most one event pulse is asserted in any cycle.
  - press and release can never coincide: a release needs at least one PRESSED cycle.
- Counter never exceeds its limit; no wrap-around outside the rules above.
- Reset mid-operation (any state):
  - All outputs drop to 0 immediately; no release pulse is generated.
  - Return to LOCKOUT; a new press requires level to fall and rise again.
- Minimum press: level high for 1 edge then low gives press in one cycle, release in the next.

Optional Feature:
- Macro: BUTTON_EVENT_AUTO_REPEAT_EN.
- Defined:
  - In HELD, counter increments each edge with level=1.
  - When counter+1 == REPEAT_CYCLES: repeat=1 one cycle, counter := 0.
  - First repeat at edge N+HOLD_CYCLES+REPEAT_CYCLES, then every REPEAT_CYCLES edges.
- Not defined:
  - repeat is tied to constant 0; the HELD-state counter logic is not synthesised and counter holds 0 in HELD.
  - All other behaviour is identical.

Test Plan (HOLD_CYCLES=5, REPEAT_CYCLES=3, 20 ms clock):
1. Reset released with level=1 for 10 cycles, then level=0, then level=1 -> no pulses during lockout; press exactly one cycle after the edge sampling the second rise.
2. From IDLE, level=1 for 2 cycles then 0 -> press one cycle, release one cycle two edges later, long_press/held stay 0.
3. From IDLE, level=1 for 12 cycles -> press at N; long_press and held rise at N+5. With macro, repeat pulses at N+8 and N+11. Without macro, repeat stays 0. Then level=0 -> release one cycle, held falls.
4. level=1 for exactly 4 cycles then 0 (one short of threshold) -> press and release only; no long_press.
5. reset asserted while in HELD -> held/all outputs 0 within the same cycle, no release. After reset with level=1 -> no press until level toggles 0→1.
6. level toggles 1,0,1,0 each cycle -> press/release alternate, never both high in one cycle, no long_press.
